// File: rtl/ckv_phase_accum_if.sv
// Bundle between the ripple-counter sampler and the ADPLL phase accumulator.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take every delta_valid strobe.
`timescale 1fs / 1fs

interface ckv_phase_accum_if #(
    parameter int CNT_W = 7,
    parameter int ACC_W = 16
);
    logic             en;
    logic             clear;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] delta;
    logic             delta_valid;
    logic [ACC_W-1:0] phase_int;
    logic             busy;
    logic             range_err;

    // Controller / counter side: drives run control and the sampled count.
    modport master (
        output en,
        output clear,
        output count,
        input  delta,
        input  delta_valid,
        input  phase_int,
        input  busy,
        input  range_err
    );

    // Accumulator side.
    modport slave (
        input  en,
        input  clear,
        input  count,
        output delta,
        output delta_valid,
        output phase_int,
        output busy,
        output range_err
    );
endinterface

// File: rtl/ckv_phase_accum.sv
// Integrates DCO edge counts into the ADPLL integer variable phase (macro CKV_PHASE_ACCUM_RANGE_CHK_EN adds a delta range check).
// Latency: count sampled at edge n shows up on delta/phase_int after edge n+1; first strobe needs IDLE->DISCARD->PRIME->RUN.
// Backpressure: none; one delta per reference clock in RUN, consumer must keep up.
`timescale 1fs / 1fs

module ckv_phase_accum #(
    parameter int CNT_W = 7,
    parameter int ACC_W = 16
`ifdef CKV_PHASE_ACCUM_RANGE_CHK_EN
    ,
    parameter logic [CNT_W-1:0] DELTA_MIN = CNT_W'(20),
    parameter logic [CNT_W-1:0] DELTA_MAX = CNT_W'(60)
`endif
) (
    input  logic               clk,
    input  logic               rst,
    ckv_phase_accum_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISCARD = 2'd1,
        ST_PRIME   = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] delta_q, delta_d;
    logic             delta_valid_q, delta_valid_d;
    logic [ACC_W-1:0] phase_q, phase_d;

    // Edge count over the last reference period; the ripple counter wraps,
    // so a plain truncated subtract gives the right answer across the wrap.
    logic [CNT_W-1:0] diff;
    logic [ACC_W-1:0] diff_ext;
    logic             acc_ok;

`ifdef CKV_PHASE_ACCUM_RANGE_CHK_EN
    logic             range_err_q, range_err_d;
    logic             diff_in_range;
`endif

    // Modular difference against the previous sample, zero-extended for the accumulator.
    always_comb begin
        diff     = bus.count - prev_q;
        diff_ext = ACC_W'(diff);
    end

`ifdef CKV_PHASE_ACCUM_RANGE_CHK_EN
    // Out-of-range deltas are reported but kept out of the phase integral.
    always_comb begin
        diff_in_range = (diff >= DELTA_MIN) && (diff <= DELTA_MAX);
        acc_ok        = diff_in_range;
    end
`else
    // Without the range check every delta is accumulated.
    always_comb begin
        acc_ok = 1'b1;
    end
`endif

    // Next-state and datapath update for the sampling sequence.
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        delta_d       = delta_q;
        delta_valid_d = 1'b0;
        phase_d       = phase_q;

        if (!bus.en) begin
            // Dropping enable parks the block; delta, prev and phase hold.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_DISCARD;
                end
                ST_DISCARD: begin
                    // First sample after enable may be skewed across the latch chain.
                    state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    prev_d  = bus.count;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    delta_d       = diff;
                    prev_d        = bus.count;
                    delta_valid_d = 1'b1;
                    if (acc_ok) begin
                        phase_d = phase_q + diff_ext;
                    end
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Clear beats accumulation on the same edge and works in every state.
        if (bus.clear) begin
            phase_d = '0;
        end
    end

`ifdef CKV_PHASE_ACCUM_RANGE_CHK_EN
    // Sticky range flag; a fresh violation on the clearing edge still wins.
    always_comb begin
        range_err_d = range_err_q;
        if (bus.clear) begin
            range_err_d = 1'b0;
        end
        if (bus.en && (state_q == ST_RUN) && !diff_in_range) begin
            range_err_d = 1'b1;
        end
    end

    // Range flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign bus.range_err = range_err_q;
`else
    assign bus.range_err = 1'b0;
`endif

    // State and datapath registers; reset discards prev and the integral.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prev_q        <= '0;
            delta_q       <= '0;
            delta_valid_q <= 1'b0;
            phase_q       <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            delta_q       <= delta_d;
            delta_valid_q <= delta_valid_d;
            phase_q       <= phase_d;
        end
    end

    assign bus.delta       = delta_q;
    assign bus.delta_valid = delta_valid_q;
    assign bus.phase_int   = phase_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ckv_phase_accum.sv
// Directed bench for ckv_phase_accum: stimulus queues expected strobes, a monitor checks them.
// Latency: expectations are tagged with the edge that should produce them.
// Backpressure: none; every delta_valid strobe is consumed by the monitor.
`timescale 1fs / 1fs

module tb_ckv_phase_accum;
    localparam int CNT_W = 7;
    localparam int ACC_W = 16;

    logic clk = 1'b0;
    logic rst;

    ckv_phase_accum_if #(.CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

    ckv_phase_accum #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [CNT_W-1:0] d;
        logic [ACC_W-1:0] p;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_no  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one valid check per edge, then pop and compare the strobe contents.
    always @(posedge clk) begin : mon
        exp_t e;
        logic exp_v;
        edge_no++;
        #1;
        while (sb_q.size() != 0 && sb_q[0].cyc < edge_no) begin
            n_checks++;
            n_errors++;
            $display("FAIL missed_strobe: got none at edge %0d required delta=%0d phase=%0h",
                     sb_q[0].cyc, sb_q[0].d, sb_q[0].p);
            void'(sb_q.pop_front());
        end
        exp_v = (sb_q.size() != 0) && (sb_q[0].cyc == edge_no);
        chk("delta_valid", 32'(bus.delta_valid), 32'(exp_v));
        if (exp_v) begin
            e = sb_q.pop_front();
            if (bus.delta_valid === 1'b1) begin
                chk("delta", 32'(bus.delta), 32'(e.d));
                chk("phase_int", 32'(bus.phase_int), 32'(e.p));
            end
        end
    end

    // One reference period: drive inputs mid-cycle, optionally queue the strobe due at the next edge.
    task automatic step(input logic e, input logic c, input logic [CNT_W-1:0] cnt,
                        input logic v, input logic [CNT_W-1:0] ed, input logic [ACC_W-1:0] ep);
        @(negedge clk);
        bus.en    = e;
        bus.clear = c;
        bus.count = cnt;
        if (v) sb_q.push_back('{cyc: edge_no + 1, d: ed, p: ep});
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_delta"}, 32'(bus.delta), 32'd0);
        chk({tag, "_valid"}, 32'(bus.delta_valid), 32'd0);
        chk({tag, "_phase"}, 32'(bus.phase_int), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_range_err"}, 32'(bus.range_err), 32'd0);
    endtask

    task automatic start_run();
        step(1'b1, 1'b0, 7'd0, 1'b0, 7'd0, 16'd0);
        chk("busy_discard", 32'(bus.busy), 32'd1);
    endtask

    // Watchdog: everything is clocked, so this only trips on a broken clock/sim.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CNT_W-1:0] c7;
        rst       = 1'b1;
        bus.en    = 1'b0;
        bus.clear = 1'b0;
        bus.count = '0;
        repeat (2) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

`ifdef CKV_PHASE_ACCUM_RANGE_CHK_EN
        start_run();
        step(1'b1, 1'b0, 7'd0,   1'b0, 7'd0,  16'd0);
        step(1'b1, 1'b0, 7'd0,   1'b0, 7'd0,  16'd0);   // prime prev=0
        step(1'b1, 1'b0, 7'd40,  1'b1, 7'd40, 16'd40);
        chk("range_ok", 32'(bus.range_err), 32'd0);
        step(1'b1, 1'b0, 7'd110, 1'b1, 7'd70, 16'd40);  // 70 out of range: phase holds
        chk("range_set", 32'(bus.range_err), 32'd1);
        step(1'b1, 1'b0, 7'd22,  1'b1, 7'd40, 16'd80);
        chk("range_sticky", 32'(bus.range_err), 32'd1);
        step(1'b1, 1'b1, 7'd62,  1'b1, 7'd40, 16'd0);
        chk("range_clear", 32'(bus.range_err), 32'd0);
        step(1'b1, 1'b0, 7'd82,  1'b1, 7'd20, 16'd20);  // DELTA_MIN is legal
        step(1'b1, 1'b0, 7'd14,  1'b1, 7'd60, 16'd80);  // DELTA_MAX is legal
        chk("range_edges", 32'(bus.range_err), 32'd0);
        step(1'b1, 1'b0, 7'd33,  1'b1, 7'd19, 16'd80);  // one below DELTA_MIN
        chk("range_below_min", 32'(bus.range_err), 32'd1);
`else
        // Steady 40 edges per period; DISCARD and PRIME produce no strobe.
        start_run();
        step(1'b1, 1'b0, 7'd40,  1'b0, 7'd0,  16'd0);
        step(1'b1, 1'b0, 7'd80,  1'b0, 7'd0,  16'd0);   // prime prev=80
        step(1'b1, 1'b0, 7'd120, 1'b1, 7'd40, 16'd40);
        step(1'b1, 1'b0, 7'd32,  1'b1, 7'd40, 16'd80);
        step(1'b1, 1'b0, 7'd72,  1'b1, 7'd40, 16'd120);
        step(1'b1, 1'b0, 7'd112, 1'b1, 7'd40, 16'd160);
        step(1'b1, 1'b0, 7'd120, 1'b1, 7'd8,  16'd168);
        // Counter wrap: 120 -> 5 is 13 edges.
        step(1'b1, 1'b0, 7'd5,   1'b1, 7'd13, 16'd181);
        chk("busy_run", 32'(bus.busy), 32'd1);

        // Enable drop: everything holds, block parks in IDLE.
        step(1'b0, 1'b0, 7'd50, 1'b0, 7'd0, 16'd0);
        chk("drop_phase", 32'(bus.phase_int), 32'd181);
        chk("drop_delta", 32'(bus.delta), 32'd13);
        chk("drop_busy", 32'(bus.busy), 32'd0);
        step(1'b0, 1'b0, 7'd60, 1'b0, 7'd0, 16'd0);
        step(1'b0, 1'b0, 7'd70, 1'b0, 7'd0, 16'd0);
        step(1'b0, 1'b0, 7'd80, 1'b0, 7'd0, 16'd0);
        chk("drop_phase_hold", 32'(bus.phase_int), 32'd181);
        start_run();
        step(1'b1, 1'b0, 7'd10,  1'b0, 7'd0,  16'd0);
        step(1'b1, 1'b0, 7'd20,  1'b0, 7'd0,  16'd0);   // prime prev=20
        step(1'b1, 1'b0, 7'd60,  1'b1, 7'd40, 16'd221);
        step(1'b1, 1'b0, 7'd100, 1'b1, 7'd40, 16'd261);

        // Clear collides with a live delta: phase zeroed, delta still reported.
        step(1'b1, 1'b1, 7'd12,  1'b1, 7'd40, 16'd0);
        step(1'b1, 1'b0, 7'd52,  1'b1, 7'd40, 16'd40);
        // Equal samples: delta 0 is legal.
        step(1'b1, 1'b0, 7'd52,  1'b1, 7'd0,  16'd40);

        // Overflow: 560 deltas of 117 reach 0xFFF0, then +32 wraps to 0x0010.
        step(1'b1, 1'b1, 7'd52,  1'b1, 7'd0,  16'd0);
        c7 = 7'd52;
        for (int k = 1; k <= 560; k++) begin
            c7 = c7 + 7'd117;
            step(1'b1, 1'b0, c7, 1'b1, 7'd117, 16'(117 * k));
        end
        chk("preload_fff0", 32'(bus.phase_int), 32'h0000_FFF0);
        c7 = c7 + 7'd32;
        step(1'b1, 1'b0, c7, 1'b1, 7'd32, 16'h0010);

        // Async reset between edges: outputs must drop before the next edge.
        @(negedge clk);
        #2;
        rst    = 1'b1;
        bus.en = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Restart after reset: a fresh prev is primed.
        start_run();
        step(1'b1, 1'b0, 7'd0,   1'b0, 7'd0,  16'd0);
        step(1'b1, 1'b0, 7'd100, 1'b0, 7'd0,  16'd0);
        step(1'b1, 1'b0, 7'd110, 1'b1, 7'd10, 16'd10);

        // Clear while parked in IDLE.
        step(1'b0, 1'b0, 7'd110, 1'b0, 7'd0, 16'd0);
        chk("idle_phase_hold", 32'(bus.phase_int), 32'd10);
        step(1'b0, 1'b1, 7'd110, 1'b0, 7'd0, 16'd0);
        chk("idle_clear_phase", 32'(bus.phase_int), 32'd0);
        chk("idle_clear_delta", 32'(bus.delta), 32'd10);
        chk("idle_clear_busy", 32'(bus.busy), 32'd0);
`endif

        step(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 16'd0);
        step(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 16'd0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
